// File: rtl/neuron_accumulator_pkg.sv
// Shared types, widths and arithmetic helpers for the
// neuron accumulator slice.
package nn_pkg;

  localparam int DATA_W  = 17;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 16;
  localparam int FRAC_SH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    ROUND,
    HOLD
  } acc_state_t;

  typedef struct packed {
    logic [ACC_W-1:0] val;
    logic             ovf;
  } acc_sum_t;

  typedef struct packed {
    logic [OUT_W-1:0] val;
    logic             clamp;
  } act_t;

  localparam logic signed [ACC_W-1:0] OUT_MAX =
    ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] OUT_MIN =
    ACC_W'(-(2 ** (OUT_W - 1)));

  // One guard bit exposes overflow; the sum then pins to the rail.
  function automatic acc_sum_t sat_add(
    input logic signed [ACC_W-1:0] a,
    input logic signed [ACC_W-1:0] b
  );
    logic [ACC_W:0] s;
    acc_sum_t       r;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    r.ovf = s[ACC_W] ^ s[ACC_W-1];
    if (!r.ovf)
      r.val = s[ACC_W-1:0];
    else if (s[ACC_W])
      r.val = {1'b1, {(ACC_W-1){1'b0}}};
    else
      r.val = {1'b0, {(ACC_W-1){1'b1}}};
    return r;
  endfunction

  function automatic act_t shift_saturate(
    input logic signed [ACC_W-1:0] acc,
    input logic                    relu,
    input int unsigned             sh
  );
    logic signed [ACC_W-1:0] s;
    act_t                    r;
    s = acc >>> sh;
    if (relu && s[ACC_W-1])
      s = '0;
    r.clamp = 1'b0;
    r.val   = s[OUT_W-1:0];
    if (s > OUT_MAX) begin
      r.val   = OUT_MAX[OUT_W-1:0];
      r.clamp = 1'b1;
    end else if (s < OUT_MIN) begin
      r.val   = OUT_MIN[OUT_W-1:0];
      r.clamp = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_accumulator_if.sv
// Beat input and result output handshakes of the
// neuron accumulator.
interface neuron_accumulator_if
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ACC_WIDTH  = ACC_W,
  parameter int OUT_WIDTH  = OUT_W
) ();

  logic signed [ACC_WIDTH-1:0]  bias_in;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         valid_in;
  logic                         last_in;
  logic                         relu_en_in;
  logic                         ready_out;
  logic signed [OUT_WIDTH-1:0]  result_out;
  logic                         sat_out;
  logic                         valid_out;
  logic                         ready_in;

  modport master (
    output bias_in, data_in, valid_in,
    output last_in, relu_en_in, ready_in,
    input  ready_out, result_out,
    input  sat_out, valid_out
  );

  modport slave (
    input  bias_in, data_in, valid_in,
    input  last_in, relu_en_in, ready_in,
    output ready_out, result_out,
    output sat_out, valid_out
  );

endinterface

// File: rtl/neuron_accumulator_shift_saturate.sv
// Combinational fixed-point rescale, optional ReLU
// and clamp of the accumulator into the result width.
module nn_shift_saturate
  import nn_pkg::*;
#(
  parameter int FRAC_SHIFT = FRAC_SH
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] result,
  output logic                    clamp
);

  act_t act;

  assign act    = shift_saturate(acc, relu_en, FRAC_SHIFT);
  assign result = act.val;
  assign clamp  = act.clamp;

endmodule

// File: rtl/neuron_accumulator.sv
// Bias-seeded saturating accumulator of adder-tree sums,
// emitting one rescaled activation per neuron.
module neuron_accumulator
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ACC_WIDTH  = ACC_W,
  parameter int OUT_WIDTH  = OUT_W,
  parameter int FRAC_SHIFT = FRAC_SH
) (
  input logic                 clk_in,
  input logic                 rst_n_in,
  neuron_accumulator_if.slave bus
);

  acc_state_t                  state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        sticky;
  logic                        relu_q;

  logic signed [ACC_WIDTH-1:0] data_ext;
  logic signed [ACC_WIDTH-1:0] add_base;
  acc_sum_t                    sum;
  logic signed [OUT_WIDTH-1:0] act_val;
  logic                        act_clamp;
  logic                        take;

  assign data_ext = {
    {(ACC_WIDTH-DATA_WIDTH){bus.data_in[DATA_WIDTH-1]}},
    bus.data_in
  };

  // The first beat of a neuron adds onto the bias, not the old acc.
  assign add_base = (state == IDLE) ? bus.bias_in : acc;
  assign sum      = sat_add(add_base, data_ext);

  assign bus.ready_out = (state == IDLE) || (state == ACCUM);
  assign take          = bus.valid_in && bus.ready_out;

  nn_shift_saturate #(
    .FRAC_SHIFT(FRAC_SHIFT)
  ) u_shift_sat (
    .acc     (acc),
    .relu_en (relu_q),
    .result  (act_val),
    .clamp   (act_clamp)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      acc            <= '0;
      sticky         <= 1'b0;
      relu_q         <= 1'b0;
      bus.result_out <= '0;
      bus.sat_out    <= 1'b0;
      bus.valid_out  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (take) begin
            acc <= sum.val;
            if (state == IDLE)
              sticky <= sum.ovf;
            else
              sticky <= sticky | sum.ovf;
            if (bus.last_in) begin
              relu_q <= bus.relu_en_in;
              state  <= ROUND;
            end else begin
              state  <= ACCUM;
            end
          end
        end
        ROUND: begin
          bus.result_out <= act_val;
          bus.sat_out    <= act_clamp | sticky;
          bus.valid_out  <= 1'b1;
          state          <= HOLD;
        end
        HOLD: begin
          if (bus.ready_in) begin
            bus.valid_out <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Table-driven and randomized bench for
// neuron_accumulator with a behavioural reference model.
module tb_neuron_accumulator;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  neuron_accumulator_if bus ();

  neuron_accumulator dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string  name;
    longint bias;
    int     nb;
    int     beats[8];
    bit     relu;
    int     hold;
    int     exp_res;
    bit     exp_sat;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic add_vec(input string nm, input longint bias,
                         input int nb, input int b0, input int b1,
                         input int b2, input bit relu, input int hold,
                         input int res, input bit sat);
    vec_t v;
    v.name = nm;
    v.bias = bias;
    v.nb = nb;
    foreach (v.beats[i]) v.beats[i] = 0;
    v.beats[0] = b0;
    v.beats[1] = b1;
    v.beats[2] = b2;
    v.relu = relu;
    v.hold = hold;
    v.exp_res = res;
    v.exp_sat = sat;
    vq.push_back(v);
  endtask

  // Neuron value from plain integer arithmetic: running sum clamped
  // to 32-bit range, floor divide by 256, ReLU, clamp to 16 bits.
  function automatic void ref_model(input longint bias, input int nb,
                                    input int beats[8], input bit relu,
                                    output int res, output bit sat);
    longint amax = 64'sd2147483647;
    longint amin = -64'sd2147483648;
    longint acc, s, rem;
    bit ovf = 0;
    acc = bias;
    for (int i = 0; i < nb; i++) begin
      acc = acc + beats[i];
      if (acc > amax) begin acc = amax; ovf = 1; end
      if (acc < amin) begin acc = amin; ovf = 1; end
    end
    rem = ((acc % 256) + 256) % 256;
    s = (acc - rem) / 256;
    if (relu && s < 0) s = 0;
    sat = ovf;
    if (s > 32767) begin s = 32767; sat = 1; end
    if (s < -32768) begin s = -32768; sat = 1; end
    res = int'(s);
  endfunction

  task automatic drive_beat(input longint bias, input int d,
                            input bit last, input bit relu);
    bus.bias_in    = 32'(bias);
    bus.data_in    = 17'(d);
    bus.valid_in   = 1'b1;
    bus.last_in    = last;
    bus.relu_en_in = relu;
    @(posedge clk);
    #1;
  endtask

  task automatic run_neuron(input string nm, input longint bias,
                            input int nb, input int beats[8],
                            input bit relu, input int hold,
                            input int exp_res, input bit exp_sat,
                            input bit bubbles);
    int res_seen;
    bus.ready_in = (hold == 0);
    for (int i = 0; i < nb; i++) begin
      if (bubbles && ($urandom % 3 == 0)) begin
        bus.valid_in = 1'b0;
        bus.last_in  = 1'($urandom);
        bus.data_in  = 17'($urandom);
        @(posedge clk);
        #1;
      end
      chk({nm, " ready_out"}, bus.ready_out, 1);
      drive_beat(i == 0 ? bias : longint'($urandom), beats[i],
                 i == nb - 1, i == nb - 1 ? relu : !relu);
    end
    // Garbage beats while busy must be ignored.
    bus.valid_in = 1'b1;
    bus.last_in  = 1'b1;
    bus.data_in  = 17'($urandom);
    chk({nm, " t+1 valid_out"}, bus.valid_out, 0);
    chk({nm, " round ready_out"}, bus.ready_out, 0);
    @(posedge clk);
    #1;
    chk({nm, " t+2 valid_out"}, bus.valid_out, 1);
    chk({nm, " result"}, bus.result_out, exp_res);
    chk({nm, " sat"}, bus.sat_out, exp_sat);
    res_seen = int'(bus.result_out);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      chk({nm, " hold valid_out"}, bus.valid_out, 1);
      chk({nm, " hold result"}, bus.result_out, res_seen);
      chk({nm, " hold ready_out"}, bus.ready_out, 0);
    end
    bus.ready_in = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.last_in  = 1'b0;
    bus.ready_in = 1'b0;
    chk({nm, " drain valid_out"}, bus.valid_out, 0);
    chk({nm, " idle ready_out"}, bus.ready_out, 1);
  endtask

  initial begin
    int b[8];
    int r;
    bit s;

    rst_n          = 1'b0;
    bus.bias_in    = '0;
    bus.data_in    = '0;
    bus.valid_in   = 1'b0;
    bus.last_in    = 1'b0;
    bus.relu_en_in = 1'b0;
    bus.ready_in   = 1'b0;
    #12;
    chk("reset valid_out", bus.valid_out, 0);
    chk("reset result_out", bus.result_out, 0);
    chk("reset sat_out", bus.sat_out, 0);
    chk("reset ready_out", bus.ready_out, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset ready_out", bus.ready_out, 1);

    add_vec("basic", 256, 3, 512, 256, -256, 0, 0, 3, 0);
    add_vec("floor", 0, 1, -1000, 0, 0, 0, 0, -4, 0);
    add_vec("relu", 0, 1, -1000, 0, 0, 1, 0, 0, 0);
    add_vec("sat_hi", 64'h7FFFFF00, 1, 65535, 0, 0, 0, 0, 32767, 1);
    add_vec("sat_lo", -64'sd2147483392, 1, -65536, 0, 0, 0, 0,
            -32768, 1);
    add_vec("sat_lo_relu", -64'sd2147483392, 1, -65536, 0, 0, 1, 0,
            0, 1);
    add_vec("edge_max", 8388352, 1, 255, 0, 0, 0, 0, 32767, 0);
    add_vec("over_max", 8388608, 1, 0, 0, 0, 0, 0, 32767, 1);
    add_vec("edge_min", -8388608, 1, 0, 0, 0, 0, 0, -32768, 0);
    add_vec("under_min", -8388609, 1, 0, 0, 0, 0, 0, -32768, 1);
    add_vec("backpressure", 256, 3, 512, 256, -256, 0, 5, 3, 0);
    add_vec("after_bp", 0, 2, 1024, 256, 0, 0, 0, 5, 0);

    foreach (vq[i])
      run_neuron(vq[i].name, vq[i].bias, vq[i].nb, vq[i].beats,
                 vq[i].relu, vq[i].hold, vq[i].exp_res,
                 vq[i].exp_sat, 0);

    // Abort in ACCUM: two of four beats, then reset.
    drive_beat(1000, 256, 0, 0);
    drive_beat(0, 256, 0, 0);
    bus.valid_in = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("abort accum valid_out", bus.valid_out, 0);
    chk("abort accum ready_out", bus.ready_out, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort accum no result", bus.valid_out, 0);
    for (int i = 0; i < 8; i++) b[i] = 0;
    b[0] = 512;
    run_neuron("after_abort", 0, 1, b, 0, 0, 2, 0, 0);

    // Abort in HOLD: result is withdrawn immediately.
    bus.ready_in = 1'b0;
    drive_beat(0, 2560, 1, 0);
    bus.valid_in = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-abort hold valid_out", bus.valid_out, 1);
    rst_n = 1'b0;
    #2;
    chk("abort hold valid_out", bus.valid_out, 0);
    chk("abort hold result_out", bus.result_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      longint bias;
      int nb;
      bit relu;
      logic signed [16:0] d;
      if ($urandom % 4 == 0)
        bias = longint'($signed(32'($urandom)));
      else
        bias = longint'($urandom_range(0, 1 << 22)) - (1 << 21);
      nb = int'($urandom_range(1, 6));
      for (int i = 0; i < 8; i++) begin
        d = 17'($urandom);
        b[i] = int'(d);
      end
      relu = 1'($urandom);
      ref_model(bias, nb, b, relu, r, s);
      run_neuron("random", bias, nb, b, relu,
                 int'($urandom_range(0, 3)), r, s, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
